// File: rtl/daq_readout_pg.sv
// daq_readout_pg: circular raw hit buffer, L1A queue and DAQ frame serialiser.
// Define DAQ_READOUT_CRC_EN to add a CRC-12 word between the data and the trailer.
module daq_readout_pg #(
  parameter int NLAYERS  = 6,
  parameter int LY_WIDTH = 96,
  parameter int RAW_AW   = 8,
  parameter int L1Q_AW   = 3
) (
  input  logic                        clk,
  input  logic                        hard_rst,
  input  logic [NLAYERS*LY_WIDTH-1:0] ly_in,
  input  logic [11:0]                 bxn,
  input  logic                        l1a,
  input  logic [RAW_AW-1:0]           l1a_delay,
  input  logic [4:0]                  fifo_pretrig,
  input  logic [4:0]                  fifo_tbins,
  input  logic                        zero_suppress,
  input  logic                        trig_stop,
  output logic [18:0]                 daq_data,
  output logic                        daq_valid,
  input  logic                        daq_ready,
  output logic                        daq_last,
  output logic                        busy,
  output logic                        l1a_q_full,
  output logic [7:0]                  l1a_dropped
);
  localparam int CHUNKS = LY_WIDTH / 12;
  localparam int CHW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int TW = NLAYERS * LY_WIDTH;
  localparam int QD = 2 ** L1Q_AW;
  localparam int QW = RAW_AW + 24;

`ifdef DAQ_READOUT_CRC_EN
  typedef enum logic [2:0] {
    IDLE, LOAD, HDR0, HDR1, HDR2, DATA, CRC, TRL
  } state_t;
  localparam state_t POST = CRC;
`else
  typedef enum logic [2:0] {
    IDLE, LOAD, HDR0, HDR1, HDR2, DATA, TRL
  } state_t;
  localparam state_t POST = TRL;
`endif

  state_t state, state_nxt;
  logic [TW-1:0] mem [2**RAW_AW];
  logic [TW-1:0] rd_q;
  logic [RAW_AW-1:0] wr_ptr, addr, addr_nxt, l1a_start;
  logic [QW-1:0] q_mem [QD];
  logic [QW-1:0] q_head;
  logic [L1Q_AW:0] q_wp, q_rp;
  logic q_empty, q_push, q_pop;
  logic [11:0] l1a_count, l1a_count_nxt;
  logic [RAW_AW-1:0] f_start;
  logic [11:0] f_bxn, f_l1c, word_cnt;
  logic [4:0] f_tbins, tb;
  logic f_zs;
  logic [3:0] ly;
  logic [CHW-1:0] ch;
  logic [LY_WIDTH-1:0] cur_ly;
  logic [11:0] cur_chunk;
  logic tb_skip, ly_zero, ly_end, tb_end, acc;
`ifdef DAQ_READOUT_CRC_EN
  logic [11:0] crc;

  function automatic logic [11:0] crc12(
    input logic [11:0] c,
    input logic [11:0] d
  );
    logic [11:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[11] ^ d[i]) r = {r[10:0], 1'b0} ^ 12'h80F;
      else r = {r[10:0], 1'b0};
    end
    return r;
  endfunction
`endif

  assign l1a_start = wr_ptr - l1a_delay - RAW_AW'(fifo_pretrig);
  assign l1a_count_nxt = l1a_count + 12'd1;
  assign q_empty = (q_wp == q_rp);
  assign l1a_q_full = (q_wp[L1Q_AW] != q_rp[L1Q_AW]) &&
    (q_wp[L1Q_AW-1:0] == q_rp[L1Q_AW-1:0]);
  assign q_push = l1a && !l1a_q_full;
  assign q_pop = (state == IDLE) && !q_empty;
  assign q_head = q_mem[q_rp[L1Q_AW-1:0]];
  assign busy = (state != IDLE);
  assign acc = daq_valid && daq_ready;

  // Read address is registered from the next address so the tbin is ready with no bubble
  always_ff @(posedge clk) begin
    if (!trig_stop) mem[wr_ptr] <= ly_in;
    rd_q <= mem[addr_nxt];
    if (q_push) q_mem[q_wp[L1Q_AW-1:0]] <= {l1a_start, bxn, l1a_count_nxt};
  end

  always_comb begin
    cur_ly = '0;
    for (int k = 0; k < NLAYERS; k++)
      if (int'(ly) == k) cur_ly = rd_q[k*LY_WIDTH +: LY_WIDTH];
    cur_chunk = '0;
    for (int c = 0; c < CHUNKS; c++)
      if (int'(ch) == c) cur_chunk = cur_ly[c*12 +: 12];
  end

  assign tb_skip = f_zs && (rd_q == '0);
  assign ly_zero = f_zs && (cur_ly == '0);
  assign ly_end = tb_skip || ly_zero || (int'(ch) == CHUNKS - 1);
  assign tb_end = tb_skip || (ly_end && int'(ly) == NLAYERS - 1);

  always_comb begin
    state_nxt = state;
    addr_nxt = addr;
    daq_data = '0;
    daq_valid = 1'b0;
    daq_last = 1'b0;
    unique case (state)
      IDLE: if (!q_empty) state_nxt = LOAD;
      LOAD: begin
        addr_nxt = f_start;
        state_nxt = HDR0;
      end
      HDR0: begin
        daq_valid = 1'b1;
        daq_data = {7'h0D, f_bxn};
        if (daq_ready) state_nxt = HDR1;
      end
      HDR1: begin
        daq_valid = 1'b1;
        daq_data = {7'h0D, f_l1c};
        if (daq_ready) state_nxt = HDR2;
      end
      HDR2: begin
        daq_valid = 1'b1;
        daq_data = {7'h0A, 2'b0, f_zs, f_tbins, 4'(NLAYERS)};
        if (daq_ready) state_nxt = (f_tbins == 5'd0) ? POST : DATA;
      end
      DATA: begin
        daq_valid = 1'b1;
        if (tb_skip) daq_data = 19'h02000;
        else if (ly_zero) daq_data = 19'h01000;
        else daq_data = {7'h00, cur_chunk};
        if (daq_ready && tb_end) begin
          addr_nxt = addr + 1'b1;
          if (tb + 5'd1 == f_tbins) state_nxt = POST;
        end
      end
`ifdef DAQ_READOUT_CRC_EN
      CRC: begin
        daq_valid = 1'b1;
        daq_data = {7'h0F, crc};
        if (daq_ready) state_nxt = TRL;
      end
`endif
      TRL: begin
        daq_valid = 1'b1;
        daq_last = 1'b1;
        daq_data = {7'h0E, word_cnt + 12'd1};
        if (daq_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      addr <= '0;
      q_wp <= '0;
      q_rp <= '0;
      l1a_count <= '0;
      l1a_dropped <= '0;
      f_start <= '0;
      f_bxn <= '0;
      f_l1c <= '0;
      f_tbins <= '0;
      f_zs <= 1'b0;
      tb <= '0;
      ly <= '0;
      ch <= '0;
      word_cnt <= '0;
`ifdef DAQ_READOUT_CRC_EN
      crc <= '0;
`endif
    end else begin
      state <= state_nxt;
      addr <= addr_nxt;
      if (!trig_stop) wr_ptr <= wr_ptr + 1'b1;
      if (l1a) begin
        l1a_count <= l1a_count_nxt;
        if (l1a_q_full && l1a_dropped != 8'hFF)
          l1a_dropped <= l1a_dropped + 8'd1;
      end
      if (q_push) q_wp <= q_wp + 1'b1;
      if (q_pop) begin
        q_rp <= q_rp + 1'b1;
        {f_start, f_bxn, f_l1c} <= q_head;
      end
      if (state == LOAD) begin
        f_tbins <= fifo_tbins;
        f_zs <= zero_suppress;
        tb <= '0;
        ly <= '0;
        ch <= '0;
        word_cnt <= '0;
`ifdef DAQ_READOUT_CRC_EN
        crc <= '0;
`endif
      end
      if (acc) word_cnt <= word_cnt + 12'd1;
      if (state == DATA && daq_ready) begin
        if (tb_end) begin
          tb <= tb + 5'd1;
          ly <= '0;
          ch <= '0;
        end else if (ly_end) begin
          ly <= ly + 4'd1;
          ch <= '0;
        end else begin
          ch <= ch + 1'b1;
        end
      end
`ifdef DAQ_READOUT_CRC_EN
      if (acc && (state == HDR0 || state == HDR1 ||
                  state == HDR2 || state == DATA))
        crc <= crc12(crc, daq_data[11:0]);
`endif
    end
  end
endmodule

// File: tb/tb_daq_readout_pg.sv
// Directed bench for daq_readout_pg with default parameters.
// Covers frame format, zero suppression, backpressure, queue overflow, wrap, reset and CRC.
module tb_daq_readout_pg;
  localparam int NL = 6;
  localparam int LW = 96;
  localparam int TW = NL * LW;
`ifdef DAQ_READOUT_CRC_EN
  localparam int NX = 1;
`else
  localparam int NX = 0;
`endif

  logic clk = 1'b0;
  logic hard_rst = 1'b1;
  logic [TW-1:0] ly_in = '0;
  logic [11:0] bxn = '0;
  logic l1a = 1'b0;
  logic [7:0] l1a_delay = '0;
  logic [4:0] fifo_pretrig = '0;
  logic [4:0] fifo_tbins = '0;
  logic zero_suppress = 1'b0;
  logic trig_stop = 1'b1;
  logic [18:0] daq_data;
  logic daq_valid;
  logic daq_ready = 1'b0;
  logic daq_last;
  logic busy;
  logic l1a_q_full;
  logic [7:0] l1a_dropped;

  int vecs = 0;
  int errs = 0;
  int stall_err = 0;
  logic [18:0] got_q[$];
  logic got_last[$];
  int got_cyc[$];
  logic [18:0] exp_q[$];

  daq_readout_pg dut (
    .clk(clk), .hard_rst(hard_rst), .ly_in(ly_in), .bxn(bxn),
    .l1a(l1a), .l1a_delay(l1a_delay), .fifo_pretrig(fifo_pretrig),
    .fifo_tbins(fifo_tbins), .zero_suppress(zero_suppress),
    .trig_stop(trig_stop), .daq_data(daq_data), .daq_valid(daq_valid),
    .daq_ready(daq_ready), .daq_last(daq_last), .busy(busy),
    .l1a_q_full(l1a_q_full), .l1a_dropped(l1a_dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hard_rst = 1'b1;
    l1a = 1'b0;
    trig_stop = 1'b1;
    daq_ready = 1'b0;
    tick();
    tick();
    hard_rst = 1'b0;
  endtask

  task automatic write_bin(input logic [TW-1:0] img);
    trig_stop = 1'b0;
    ly_in = img;
    tick();
    trig_stop = 1'b1;
  endtask

  task automatic pulse_l1a();
    l1a = 1'b1;
    tick();
    l1a = 1'b0;
  endtask

  function automatic logic [TW-1:0] ramp_img(input int a);
    logic [TW-1:0] v = '0;
    for (int k = 0; k < NL; k++)
      for (int c = 0; c < 8; c++)
        v[k*LW+c*12 +: 12] = 12'(a * 64 + k * 8 + c);
    return v;
  endfunction

  function automatic logic [TW-1:0] wrap_img(input int a);
    logic [TW-1:0] v = '0;
    for (int k = 0; k < NL; k++)
      for (int c = 0; c < 8; c++)
        v[k*LW+c*12 +: 12] = 12'(a * 16 + k);
    return v;
  endfunction

`ifdef DAQ_READOUT_CRC_EN
  function automatic logic [11:0] crc12_ref(
    input logic [11:0] c,
    input logic [11:0] d
  );
    logic [11:0] r = c;
    for (int i = 11; i >= 0; i--)
      r = (r[11] ^ d[i]) ? ({r[10:0], 1'b0} ^ 12'h80F) : {r[10:0], 1'b0};
    return r;
  endfunction
`endif

  // Appends the optional CRC word and the trailer to the expected frame
  task automatic close_exp();
`ifdef DAQ_READOUT_CRC_EN
    logic [11:0] c = '0;
    foreach (exp_q[i]) c = crc12_ref(c, exp_q[i][11:0]);
    exp_q.push_back({7'h0F, c});
`endif
    exp_q.push_back({7'h0E, 12'(exp_q.size() + 1)});
  endtask

  task automatic build_ramp_exp();
    exp_q.delete();
    exp_q.push_back(19'h0D123);
    exp_q.push_back(19'h0D001);
    exp_q.push_back(19'h0A026);
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < NL; k++)
        for (int c = 0; c < 8; c++)
          exp_q.push_back({7'h00, 12'(t * 64 + k * 8 + c)});
    close_exp();
  endtask

  task automatic collect(input int nf, input bit bp, input int budget,
                         output bit to);
    int n = 0;
    int fr = 0;
    bit held = 1'b0;
    logic [18:0] hd = '0;
    logic hl = 1'b0;
    got_q.delete();
    got_last.delete();
    got_cyc.delete();
    stall_err = 0;
    to = 1'b0;
    while (fr < nf && !to) begin
      daq_ready = bp ? (n % 3 == 0) : 1'b1;
      @(negedge clk);
      if (held && (!daq_valid || daq_data !== hd || daq_last !== hl))
        stall_err++;
      held = daq_valid && !daq_ready;
      hd = daq_data;
      hl = daq_last;
      if (daq_valid && daq_ready) begin
        got_q.push_back(daq_data);
        got_last.push_back(daq_last);
        got_cyc.push_back(n);
        if (daq_last) fr++;
      end
      tick();
      n++;
      if (fr < nf && n >= budget) to = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (daq_valid !== 1'b0 || daq_last !== 1'b0 || daq_data !== '0) begin
      errs++;
      $display("FAIL reset_out: got v=%b l=%b d=%05h want 0/0/00000",
               daq_valid, daq_last, daq_data);
    end
    vecs++;
    if (busy !== 1'b0 || l1a_q_full !== 1'b0) begin
      errs++;
      $display("FAIL reset_status: got busy=%b full=%b want 0/0", busy, l1a_q_full);
    end
    vecs++;
    if (l1a_dropped !== 8'd0) begin
      errs++;
      $display("FAIL reset_dropped: got %0d want 0", l1a_dropped);
    end
  endtask

  task automatic test_frame(input bit bp);
    bit to;
    int nl = 0;
    do_reset();
    write_bin(ramp_img(0));
    write_bin(ramp_img(1));
    bxn = 12'h123;
    l1a_delay = 8'd2;
    fifo_pretrig = 5'd0;
    fifo_tbins = 5'd2;
    zero_suppress = 1'b0;
    pulse_l1a();
    collect(1, bp, 1000, to);
    build_ramp_exp();
    vecs++;
    if (to || got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL frame_len bp=%0b: got %0d words to=%0b want %0d",
               bp, got_q.size(), to, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vecs++;
        if (got_q[i] !== exp_q[i]) begin
          errs++;
          $display("FAIL frame_word bp=%0b idx %0d: got %05h want %05h",
                   bp, i, got_q[i], exp_q[i]);
        end
      end
      foreach (got_last[i]) nl += int'(got_last[i]);
      vecs++;
      if (nl != 1 || got_last[got_last.size()-1] !== 1'b1) begin
        errs++;
        $display("FAIL frame_last bp=%0b: got %0d last flags want 1 on trailer", bp, nl);
      end
`ifndef DAQ_READOUT_CRC_EN
      vecs++;
      if (got_q[99] !== 19'h0E064) begin
        errs++;
        $display("FAIL frame_trl: got %05h want 0e064", got_q[99]);
      end
`endif
    end
    if (bp) begin
      vecs++;
      if (stall_err != 0) begin
        errs++;
        $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_err);
      end
    end
  endtask

  task automatic test_zero_suppress();
    bit to;
    logic [TW-1:0] img = '0;
    do_reset();
    img[2*LW +: 12] = 12'hABC;
    write_bin(img);
    write_bin('0);
    bxn = 12'h456;
    l1a_delay = 8'd2;
    fifo_pretrig = 5'd0;
    fifo_tbins = 5'd2;
    zero_suppress = 1'b1;
    pulse_l1a();
    collect(1, 1'b0, 400, to);
    exp_q.delete();
    exp_q.push_back(19'h0D456);
    exp_q.push_back(19'h0D001);
    exp_q.push_back(19'h0A226);
    exp_q.push_back(19'h01000);
    exp_q.push_back(19'h01000);
    exp_q.push_back(19'h00ABC);
    for (int i = 0; i < 7; i++) exp_q.push_back(19'h00000);
    for (int i = 0; i < 3; i++) exp_q.push_back(19'h01000);
    exp_q.push_back(19'h02000);
    close_exp();
    vecs++;
    if (to || got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL zs_len: got %0d words to=%0b want %0d",
               got_q.size(), to, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vecs++;
        if (got_q[i] !== exp_q[i]) begin
          errs++;
          $display("FAIL zs_word idx %0d: got %05h want %05h", i, got_q[i], exp_q[i]);
        end
      end
    end
    zero_suppress = 1'b0;
  endtask

  task automatic test_overflow_back_to_back();
    bit to;
    int w = 4 + NX;
    int gap;
    do_reset();
    bxn = 12'h055;
    l1a_delay = 8'd0;
    fifo_pretrig = 5'd0;
    fifo_tbins = 5'd0;
    for (int i = 0; i < 10; i++) begin
      l1a = 1'b1;
      tick();
    end
    l1a = 1'b0;
    vecs++;
    if (l1a_q_full !== 1'b1 || l1a_dropped !== 8'd1) begin
      errs++;
      $display("FAIL q_over: got full=%b dropped=%0d want 1/1", l1a_q_full, l1a_dropped);
    end
    vecs++;
    if (busy !== 1'b1 || daq_valid !== 1'b1 || daq_data !== 19'h0D055) begin
      errs++;
      $display("FAIL q_stall: got busy=%b v=%b d=%05h want 1/1/0d055",
               busy, daq_valid, daq_data);
    end
    for (int i = 0; i < 300; i++) begin
      l1a = 1'b1;
      tick();
    end
    l1a = 1'b0;
    vecs++;
    if (l1a_dropped !== 8'd255) begin
      errs++;
      $display("FAIL drop_sat: got %0d want 255", l1a_dropped);
    end
    collect(9, 1'b0, 200, to);
    vecs++;
    if (to || got_q.size() != 9 * w) begin
      errs++;
      $display("FAIL q_frames: got %0d words to=%0b want %0d", got_q.size(), to, 9 * w);
    end else begin
      for (int f = 0; f < 9; f++) begin
        vecs++;
        if (got_q[f*w+1] !== {7'h0D, 12'(f + 1)} ||
            got_q[f*w+w-1] !== {7'h0E, 12'(w)}) begin
          errs++;
          $display("FAIL q_frame %0d: got hdr1=%05h trl=%05h want cnt %0d",
                   f, got_q[f*w+1], got_q[f*w+w-1], f + 1);
        end
      end
      for (int f = 0; f < 8; f++) begin
        gap = got_cyc[(f+1)*w] - got_cyc[(f+1)*w-1];
        vecs++;
        if (gap != 3) begin
          errs++;
          $display("FAIL b2b_gap %0d: got %0d cycles want 3", f, gap);
        end
      end
    end
    tick();
    tick();
    vecs++;
    if (l1a_q_full !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL q_drain: got full=%b busy=%b want 0/0", l1a_q_full, busy);
    end
  endtask

  task automatic test_wrap();
    bit to;
    int a;
    do_reset();
    for (int i = 0; i < 258; i++) write_bin(wrap_img(i % 256));
    bxn = 12'h7FF;
    l1a_delay = 8'd2;
    fifo_pretrig = 5'd2;
    fifo_tbins = 5'd4;
    zero_suppress = 1'b0;
    pulse_l1a();
    collect(1, 1'b0, 600, to);
    vecs++;
    if (to || got_q.size() != 196 + NX) begin
      errs++;
      $display("FAIL wrap_len: got %0d words to=%0b want %0d", got_q.size(), to, 196 + NX);
    end else begin
      for (int t = 0; t < 4; t++) begin
        a = (254 + t) % 256;
        vecs++;
        if (got_q[3+t*48] !== {7'h00, 12'(a * 16)} ||
            got_q[3+t*48+8] !== {7'h00, 12'(a * 16 + 1)}) begin
          errs++;
          $display("FAIL wrap_tbin %0d: got %05h/%05h want addr %0d",
                   t, got_q[3+t*48], got_q[3+t*48+8], a);
        end
      end
      vecs++;
      if (got_q[195+NX] !== {7'h0E, 12'(196 + NX)}) begin
        errs++;
        $display("FAIL wrap_trl: got %05h want %05h", got_q[195+NX], {7'h0E, 12'(196 + NX)});
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int nv = 0;
    do_reset();
    fifo_tbins = 5'd4;
    for (int i = 0; i < 10; i++) begin
      l1a = 1'b1;
      tick();
    end
    l1a = 1'b0;
    vecs++;
    if (l1a_dropped !== 8'd1) begin
      errs++;
      $display("FAIL rst_pre_drop: got %0d want 1", l1a_dropped);
    end
    daq_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    vecs++;
    if (busy !== 1'b1 || daq_valid !== 1'b1 || daq_data[18:12] !== 7'h00) begin
      errs++;
      $display("FAIL rst_in_data: got busy=%b v=%b tag=%02h want 1/1/00",
               busy, daq_valid, daq_data[18:12]);
    end
    hard_rst = 1'b1;
    tick();
    hard_rst = 1'b0;
    vecs++;
    if (daq_valid !== 1'b0 || busy !== 1'b0 || l1a_dropped !== 8'd0 ||
        l1a_q_full !== 1'b0) begin
      errs++;
      $display("FAIL rst_abort: got v=%b busy=%b drop=%0d full=%b want 0",
               daq_valid, busy, l1a_dropped, l1a_q_full);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (daq_valid) nv++;
      tick();
    end
    vecs++;
    if (nv != 0) begin
      errs++;
      $display("FAIL rst_no_trl: got %0d valid cycles want 0", nv);
    end
  endtask

`ifdef DAQ_READOUT_CRC_EN
  task automatic test_crc();
    bit to;
    logic [11:0] c = '0;
    do_reset();
    bxn = 12'h321;
    fifo_tbins = 5'd0;
    pulse_l1a();
    collect(1, 1'b0, 100, to);
    c = crc12_ref(c, 12'h321);
    c = crc12_ref(c, 12'h001);
    c = crc12_ref(c, 12'h006);
    vecs++;
    if (to || got_q.size() != 5) begin
      errs++;
      $display("FAIL crc_len: got %0d words want 5", got_q.size());
    end else begin
      vecs++;
      if (got_q[3] !== {7'h0F, c}) begin
        errs++;
        $display("FAIL crc_word: got %05h want %05h", got_q[3], {7'h0F, c});
      end
      vecs++;
      if (got_q[4] !== 19'h0E005) begin
        errs++;
        $display("FAIL crc_trl: got %05h want 0e005", got_q[4]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame(1'b0);
    test_zero_suppress();
    test_frame(1'b1);
    test_overflow_back_to_back();
    test_wrap();
    test_reset_mid_frame();
`ifdef DAQ_READOUT_CRC_EN
    test_crc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
